otg_hpi_engine: RTL and testbench
=================================

# otg_hpi_engine

Parametrised hardware transaction engine for the CY7C67200 host-port interface (HPI). It replaces software bit-banging of the HPI address, chip-select, read, write and data PIOs with a command/stream handshake. It issues single or burst accesses with programmable setup, strobe and hold timing. It sits between the NIOS-side command logic (or a keycode poller) and the top-level HPI tristate pads.

## Interface
- DATA_W, 16, HPI data width
- ADDR_W, 2, HPI address width (0 = data, 1 = mailbox, 2 = address, 3 = status)
- LEN_W, 5, burst length field width
- SETUP_CYC, 1, cycles with cs_n low before the strobe (1..15)
- STROBE_CYC, 2, cycles with r_n/w_n low (1..15)
- HOLD_CYC, 1, cycles with cs_n low after the strobe (1..15)

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle and accepting a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  HPI register address
- cmd_len  in  LEN_W  number of beats; 0 is treated as 1
- wr_data  in  DATA_W  write beat data
- wr_valid  in  1  write beat available
- wr_ready  out  1  write beat consumed (1-cycle pulse)
- rd_data  out  DATA_W  read beat data
- rd_valid  out  1  read beat valid (1-cycle pulse, no backpressure)
- done  out  1  1-cycle pulse on the last cycle of the command
- busy  out  1  command in progress
- hpi_addr  out  ADDR_W  to otg_hpi_address
- hpi_cs_n, hpi_r_n, hpi_w_n  out  1  active-low HPI strobes
- hpi_data_out  out  DATA_W  write data to pad
- hpi_data_oe  out  1  pad output enable
- hpi_data_in  in  DATA_W  read data from pad

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- One shared down-counter loads SETUP_CYC-1, STROBE_CYC-1 or HOLD_CYC-1 on each state entry. A beat counter loads max(cmd_len,1).
- IDLE: cmd_ready=1. On cmd_valid, latch write, addr and len, then go to SETUP.
- SETUP: cs_n=0, hpi_addr=latched addr, r_n=w_n=1.
  - Write: the counter does not run until a beat is held. On the first SETUP cycle with wr_valid=1, pulse wr_ready, latch wr_data into hpi_data_out and set hpi_data_oe=1. The counter starts on the following cycle.
  - Read: hpi_data_oe=0.
- STROBE: r_n=0 (read) or w_n=0 (write) for STROBE_CYC cycles. On a read, hpi_data_in is registered at the end of the last STROBE cycle.
- HOLD: strobes high, cs_n=0, write data still driven. rd_valid pulses in the first HOLD cycle with the captured data.
  - Last HOLD cycle, beats remaining: decrement the beat counter and go to SETUP. cs_n stays low and the address is unchanged, because the HPI auto-increments internally.
  - Last HOLD cycle, final beat: pulse done and go to IDLE.
- busy = !IDLE. cmd_valid outside IDLE is ignored.
- Reset values: cmd_ready=1, busy=0, done=0, wr_ready=0, rd_valid=0, rd_data=0, hpi_cs_n=hpi_r_n=hpi_w_n=1, hpi_addr=0, hpi_data_out=0, hpi_data_oe=0, FSM=IDLE.
- Reset asserted mid-command: all outputs return to reset values immediately. The burst is abandoned and no done pulse is issued.

## Timing
- All outputs are registered, so there are no glitches on the strobes.
- Read with defaults and len=1: accept at cycle 0, SETUP 1, STROBE 2-3, rd_valid and done at 4, cmd_ready=1 at 5.
- Single-beat occupancy is SETUP_CYC+STROBE_CYC+HOLD_CYC cycles plus write stall cycles. An N-beat burst is N times that.
- r_n and w_n are never both low. A strobe is never low while cs_n is high.
- When cmd_valid is held through done, the next command is accepted in the cycle cmd_ready returns.

## Test plan
- Single read, addr=3, pad drives 0xBEEF -> rd_data=0xBEEF with rd_valid at cycle 4; r_n low only during cycles 2-3; done at cycle 4.
- Single write, addr=2, wr_data=0x0500 present at accept -> w_n low cycles 2-3, hpi_data_out=0x0500 with oe=1 from cycle 1 through 4, one wr_ready pulse.
- Burst read, len=4, pad data 1,2,3,4 per beat -> four rd_valid pulses at 4-cycle spacing, cs_n continuously low for 16 cycles, one done.
- Write stall: wr_valid held low 5 cycles after accept -> SETUP extends 5 cycles, w_n stays high, then normal timing resumes.
- Parameters SETUP=2, STROBE=3, HOLD=2 with len=0 -> exactly 1 beat of 7 cycles; cmd_len=0 behaves as 1.
- Reset pulled low during STROBE of beat 2 of 4 -> strobes, cs_n and oe deasserted immediately; no done; next command after release executes normally.

Source files
------------

// File: rtl/otg_hpi_engine_if.sv
// otg_hpi_engine_if
// Bundles the command port, the write/read beat streams and the HPI pad
// signals of the HPI transaction engine.
//   slave  : the engine side (takes commands and pad read data, drives
//            handshakes, results and the pad strobes/data)
//   master : the command source plus pad model side (the NIOS command
//            logic together with the top-level tristate pads)
// Clock and reset are not part of the bundle; they stay plain ports.
interface otg_hpi_engine_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 5
);
  // command port
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  // write beat stream
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  // read beat stream and status
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              busy;

  // HPI pad side
  logic [ADDR_W-1:0] hpi_addr;
  logic              hpi_cs_n;
  logic              hpi_r_n;
  logic              hpi_w_n;
  logic [DATA_W-1:0] hpi_data_out;
  logic              hpi_data_oe;
  logic [DATA_W-1:0] hpi_data_in;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_data, wr_valid,
    input  hpi_data_in,
    output cmd_ready, wr_ready,
    output rd_data, rd_valid, done, busy,
    output hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_out, hpi_data_oe
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_data, wr_valid,
    output hpi_data_in,
    input  cmd_ready, wr_ready,
    input  rd_data, rd_valid, done, busy,
    input  hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_out, hpi_data_oe
  );
endinterface

// File: rtl/otg_hpi_engine.sv
// otg_hpi_engine
// Hardware transaction engine for the CY7C67200 host-port interface. It
// turns a single command (read/write, register address, beat count) into
// one or more HPI accesses with programmable setup, strobe and hold timing,
// replacing software bit-banging of the HPI PIOs.
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   bus            otg_hpi_engine_if.slave:
//                    cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len  command
//                    wr_data/wr_valid/wr_ready                       write beats
//                    rd_data/rd_valid                                read beats
//                    done/busy                                       status
//                    hpi_addr/hpi_cs_n/hpi_r_n/hpi_w_n               HPI strobes
//                    hpi_data_out/hpi_data_oe/hpi_data_in            HPI data pad
//
// Parameters: DATA_W, ADDR_W, LEN_W widths; SETUP_CYC, STROBE_CYC, HOLD_CYC
// phase lengths in clock cycles (each 1..15).
//
// Every output is a flop whose next value is decoded from the next state,
// so the pad strobes change only on clock edges and never glitch.
module otg_hpi_engine #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int LEN_W      = 5,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input logic             clk_clk,
  input logic             reset_reset_n,
  otg_hpi_engine_if.slave bus
);

  localparam logic [3:0]       SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0]       STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0]       HOLD_LD   = 4'(HOLD_CYC - 1);
  localparam logic [LEN_W-1:0] ONE_BEAT  = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic              write_q, write_d;
  logic              held_q, held_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              oe_q, oe_d;
  logic              wr_take;
  logic              rd_take;

  logic              cmd_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_ready_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              cs_n_q;
  logic              r_n_q;
  logic              w_n_q;

  // Next-state logic. cnt is the single phase timer, reloaded on entry to
  // each phase and leaving the phase when it reaches zero. held marks that
  // the current write beat has been taken; until then SETUP freezes the
  // timer, which is what stretches SETUP while the write stream is empty.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    write_d = write_q;
    held_d  = held_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    wr_take = 1'b0;
    rd_take = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          write_d = bus.cmd_write;
          addr_d  = bus.cmd_addr;
          beats_d = (bus.cmd_len == '0) ? ONE_BEAT : bus.cmd_len;
          held_d  = 1'b0;
        end
      end

      SETUP: begin
        if (!write_q || held_q) begin
          if (cnt_q == '0) begin
            state_d = STROBE;
            cnt_d   = STROBE_LD;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end

      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          rd_take = !write_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          if (beats_q != ONE_BEAT) begin
            // cs_n and the address stay put between beats; the HPI
            // auto-increments its own pointer.
            state_d = SETUP;
            cnt_d   = SETUP_LD;
            beats_d = beats_q - ONE_BEAT;
            held_d  = 1'b0;
          end else begin
            state_d = IDLE;
            oe_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // A write beat is taken in whichever cycle SETUP (current or about to
    // be entered) first sees wr_valid, so a beat already waiting at accept
    // costs no stall cycle.
    if ((state_d == SETUP) && write_d && !held_d && bus.wr_valid) begin
      wr_take = 1'b1;
      held_d  = 1'b1;
      dout_d  = bus.wr_data;
      oe_d    = 1'b1;
    end
  end

  // State, timers and all registered outputs. Output flops take their
  // value from the next state so they line up with the state they decode.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beats_q     <= '0;
      write_q     <= 1'b0;
      held_q      <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      oe_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      cs_n_q      <= 1'b1;
      r_n_q       <= 1'b1;
      w_n_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beats_q     <= beats_d;
      write_q     <= write_d;
      held_q      <= held_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      cmd_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == HOLD) && (cnt_d == '0) && (beats_d == ONE_BEAT);
      wr_ready_q  <= wr_take;
      rd_valid_q  <= rd_take;
      if (rd_take) begin
        rd_data_q <= bus.hpi_data_in;
      end
      cs_n_q      <= (state_d == IDLE);
      r_n_q       <= !((state_d == STROBE) && !write_d);
      w_n_q       <= !((state_d == STROBE) && write_d);
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.wr_ready     = wr_ready_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.hpi_addr     = addr_q;
  assign bus.hpi_cs_n     = cs_n_q;
  assign bus.hpi_r_n      = r_n_q;
  assign bus.hpi_w_n      = w_n_q;
  assign bus.hpi_data_out = dout_q;
  assign bus.hpi_data_oe  = oe_q;

endmodule

// File: tb/tb_otg_hpi_engine.sv
// tb_otg_hpi_engine
// Self-checking bench for otg_hpi_engine. One instance runs the default
// timing (1/2/1), a second runs SETUP=2, STROBE=3, HOLD=2. Read data and
// write pad data are scoreboarded: expected words are queued when the
// stimulus is driven and popped when the engine produces them. Cycle
// timing is checked by sampling strobes into per-cycle bit masks, where
// cycle 0 is the accept cycle.
`timescale 1ns/1ps
module tb_otg_hpi_engine;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = 5;

  logic clk_clk       = 1'b0;
  logic reset_reset_n = 1'b0;

  // 100 MHz clock
  always #5 clk_clk = ~clk_clk;

  otg_hpi_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_if ();
  otg_hpi_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) p_if ();

  otg_hpi_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)
  ) u_dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .bus          (u_if.slave)
  );

  otg_hpi_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)
  ) p_dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .bus          (p_if.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] pad_q[$];
  logic [DATA_W-1:0] exp_rd_q[$];
  logic [DATA_W-1:0] exp_wr_q[$];
  logic [DATA_W-1:0] wr_beats [4];

  logic [31:0] m_cs, m_rn, m_wn, m_oe, m_rdv, m_done, m_ready, m_wrr, m_busy;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_dout;
  logic prev_w_n = 1'b1;

  // Single comparison point: counts every check and reports a mismatch.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Bit mask with cycles lo..hi set.
  function automatic logic [31:0] span(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // All outputs of the default instance against their reset values.
  task automatic check_reset_values(input string tag);
    check_output({tag, "_ctrl"},
                 32'({u_if.cmd_ready, u_if.busy, u_if.done, u_if.wr_ready, u_if.rd_valid,
                      u_if.hpi_cs_n, u_if.hpi_r_n, u_if.hpi_w_n, u_if.hpi_data_oe}),
                 32'b1_0000_1110);
    check_output({tag, "_data"}, {u_if.hpi_data_out, u_if.rd_data}, 32'h0);
    check_output({tag, "_addr"}, 32'(u_if.hpi_addr), 32'h0);
  endtask

  // HPI pad model: presents the next queued read word as r_n falls.
  always @(negedge u_if.hpi_r_n) begin
    if (pad_q.size() > 0) u_if.hpi_data_in = pad_q.pop_front();
    else u_if.hpi_data_in = 16'hDEAD;
  end

  // Scoreboard and strobe protocol monitor, sampling on the falling edge.
  always @(negedge clk_clk) begin
    if (reset_reset_n) begin
      if (u_if.rd_valid) begin
        check_output("rd_expected_pending", 32'(exp_rd_q.size() != 0), 32'h1);
        if (exp_rd_q.size() != 0)
          check_output("rd_data", 32'(u_if.rd_data), 32'(exp_rd_q.pop_front()));
      end
      if (!u_if.hpi_w_n && prev_w_n) begin
        check_output("wr_expected_pending", 32'(exp_wr_q.size() != 0), 32'h1);
        if (exp_wr_q.size() != 0)
          check_output("wr_pad_data", 32'(u_if.hpi_data_out), 32'(exp_wr_q.pop_front()));
        check_output("wr_pad_oe", 32'(u_if.hpi_data_oe), 32'h1);
      end
      if (!u_if.hpi_r_n || !u_if.hpi_w_n) begin
        check_output("strobe_under_cs", 32'(u_if.hpi_cs_n), 32'h0);
        check_output("strobe_exclusive", 32'(u_if.hpi_r_n | u_if.hpi_w_n), 32'h1);
      end
    end
    prev_w_n = u_if.hpi_w_n;
  end

  // Issues one command on the default instance (called at a falling edge)
  // and samples ncyc cycles after accept into the masks. Write beats come
  // from wr_beats[0..nbeats-1], first offered in cycle wr_start. cmd_valid
  // stays high through cycle valid_until. rst_at > 0 pulls reset low in
  // that cycle and releases it two cycles later.
  task automatic apply_stimulus(input logic write, input logic [ADDR_W-1:0] addr,
                                input logic [LEN_W-1:0] len, input int nbeats,
                                input int wr_start, input int ncyc,
                                input int rst_at, input int valid_until);
    int idx;
    int wait_cyc;
    idx = 0;
    wait_cyc = 0;
    m_cs = '0; m_rn = '0; m_wn = '0; m_oe = '0; m_rdv = '0;
    m_done = '0; m_ready = '0; m_wrr = '0; m_busy = '0;
    while (!u_if.cmd_ready && wait_cyc < 50) begin
      @(negedge clk_clk);
      wait_cyc++;
    end
    check_output("cmd_ready_before_accept", 32'(u_if.cmd_ready), 32'h1);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_write = write;
    u_if.cmd_addr  = addr;
    u_if.cmd_len   = len;
    if (write && wr_start == 0 && nbeats > 0) begin
      u_if.wr_valid = 1'b1;
      u_if.wr_data  = wr_beats[0];
      exp_wr_q.push_back(wr_beats[0]);
    end
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk_clk);
      if (k > valid_until) u_if.cmd_valid = 1'b0;
      m_cs[k]    = !u_if.hpi_cs_n;
      m_rn[k]    = !u_if.hpi_r_n;
      m_wn[k]    = !u_if.hpi_w_n;
      m_oe[k]    = u_if.hpi_data_oe;
      m_rdv[k]   = u_if.rd_valid;
      m_done[k]  = u_if.done;
      m_ready[k] = u_if.cmd_ready;
      m_wrr[k]   = u_if.wr_ready;
      m_busy[k]  = u_if.busy;
      if (k == 1) s_dout = u_if.hpi_data_out;
      if (k == 2) s_addr = u_if.hpi_addr;
      if (write) begin
        if (u_if.wr_ready && u_if.wr_valid) begin
          idx++;
          u_if.wr_valid = 1'b0;
        end
        if (k >= wr_start && idx < nbeats && !u_if.wr_valid) begin
          u_if.wr_valid = 1'b1;
          u_if.wr_data  = wr_beats[idx];
          exp_wr_q.push_back(wr_beats[idx]);
        end
      end
      if (rst_at > 0 && k == rst_at) begin
        #2 reset_reset_n = 1'b0;
        #1 check_reset_values("midcmd_reset");
      end
      if (rst_at > 0 && k == rst_at + 2) begin
        #2 reset_reset_n = 1'b1;
      end
    end
    u_if.cmd_valid = 1'b0;
  endtask

  // Bench watchdog.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog elapsed=100000ns limit=100000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic [31:0] pm_busy, pm_cs, pm_rn, pm_rdv, pm_done;
    logic [DATA_W-1:0] p_rd;

    u_if.cmd_valid = 1'b0; u_if.cmd_write = 1'b0; u_if.cmd_addr = '0; u_if.cmd_len = '0;
    u_if.wr_valid  = 1'b0; u_if.wr_data   = '0;
    p_if.cmd_valid = 1'b0; p_if.cmd_write = 1'b0; p_if.cmd_addr = '0; p_if.cmd_len = '0;
    p_if.wr_valid  = 1'b0; p_if.wr_data   = '0; p_if.hpi_data_in = 16'h1234;

    repeat (3) @(negedge clk_clk);
    check_reset_values("reset_state");
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // single read, addr 3
    pad_q.push_back(16'hBEEF); exp_rd_q.push_back(16'hBEEF);
    apply_stimulus(1'b0, 2'd3, 5'd1, 0, 0, 8, 0, 0);
    check_output("rd1_cs", m_cs, span(1, 4));
    check_output("rd1_rn", m_rn, span(2, 3));
    check_output("rd1_wn", m_wn, 32'h0);
    check_output("rd1_oe", m_oe, 32'h0);
    check_output("rd1_rd_valid", m_rdv, span(4, 4));
    check_output("rd1_done", m_done, span(4, 4));
    check_output("rd1_cmd_ready", m_ready, span(5, 8));
    check_output("rd1_busy", m_busy, span(1, 4));
    check_output("rd1_addr", 32'(s_addr), 32'h3);

    // single write, addr 2, beat waiting at accept
    wr_beats[0] = 16'h0500;
    apply_stimulus(1'b1, 2'd2, 5'd1, 1, 0, 8, 0, 0);
    check_output("wr1_wn", m_wn, span(2, 3));
    check_output("wr1_rn", m_rn, 32'h0);
    check_output("wr1_oe", m_oe, span(1, 4));
    check_output("wr1_wr_ready", m_wrr, span(1, 1));
    check_output("wr1_done", m_done, span(4, 4));
    check_output("wr1_cs", m_cs, span(1, 4));
    check_output("wr1_dout_cycle1", 32'(s_dout), 32'h0500);
    check_output("wr1_addr", 32'(s_addr), 32'h2);

    // burst read of four beats
    for (int i = 1; i <= 4; i++) begin
      pad_q.push_back(DATA_W'(i)); exp_rd_q.push_back(DATA_W'(i));
    end
    apply_stimulus(1'b0, 2'd0, 5'd4, 0, 0, 20, 0, 0);
    check_output("brd_cs", m_cs, span(1, 16));
    check_output("brd_rn", m_rn, span(2, 3) | span(6, 7) | span(10, 11) | span(14, 15));
    check_output("brd_rd_valid", m_rdv, span(4, 4) | span(8, 8) | span(12, 12) | span(16, 16));
    check_output("brd_done", m_done, span(16, 16));
    check_output("brd_cmd_ready", m_ready, span(17, 20));

    // write with the beat stream empty for five cycles after accept
    wr_beats[0] = 16'hA5C3;
    apply_stimulus(1'b1, 2'd0, 5'd1, 1, 5, 12, 0, 0);
    check_output("stall_cs", m_cs, span(1, 9));
    check_output("stall_wn", m_wn, span(7, 8));
    check_output("stall_wr_ready", m_wrr, span(6, 6));
    check_output("stall_oe", m_oe, span(6, 9));
    check_output("stall_done", m_done, span(9, 9));

    // cmd_valid held through done: second read accepted as cmd_ready returns
    pad_q.push_back(16'h1111); exp_rd_q.push_back(16'h1111);
    pad_q.push_back(16'h2222); exp_rd_q.push_back(16'h2222);
    apply_stimulus(1'b0, 2'd1, 5'd1, 0, 0, 12, 0, 5);
    check_output("b2b_cs", m_cs, span(1, 4) | span(6, 9));
    check_output("b2b_cmd_ready", m_ready, span(5, 5) | span(10, 12));
    check_output("b2b_done", m_done, span(4, 4) | span(9, 9));
    check_output("b2b_rd_valid", m_rdv, span(4, 4) | span(9, 9));

    // second instance: SETUP=2 STROBE=3 HOLD=2, len=0 acts as one beat
    pm_busy = '0; pm_cs = '0; pm_rn = '0; pm_rdv = '0; pm_done = '0; p_rd = '0;
    check_output("p_cmd_ready", 32'(p_if.cmd_ready), 32'h1);
    p_if.cmd_valid = 1'b1; p_if.cmd_write = 1'b0; p_if.cmd_addr = 2'd0; p_if.cmd_len = 5'd0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_clk);
      p_if.cmd_valid = 1'b0;
      pm_busy[k] = p_if.busy;
      pm_cs[k]   = !p_if.hpi_cs_n;
      pm_rn[k]   = !p_if.hpi_r_n;
      pm_rdv[k]  = p_if.rd_valid;
      pm_done[k] = p_if.done;
      if (p_if.rd_valid) p_rd = p_if.rd_data;
    end
    check_output("p_busy", pm_busy, span(1, 7));
    check_output("p_cs", pm_cs, span(1, 7));
    check_output("p_rn", pm_rn, span(3, 5));
    check_output("p_rd_valid", pm_rdv, span(6, 6));
    check_output("p_done", pm_done, span(7, 7));
    check_output("p_rd_data", 32'(p_rd), 32'h1234);

    // reset during the strobe of beat 2 of a 4-beat write burst
    wr_beats[0] = 16'h00A1; wr_beats[1] = 16'h00B2;
    apply_stimulus(1'b1, 2'd0, 5'd4, 2, 0, 14, 6, 0);
    check_output("rst_done_absent", m_done, 32'h0);
    check_output("rst_wn", m_wn, span(2, 3) | span(6, 6));
    check_output("rst_cs", m_cs, span(1, 6));
    check_output("rst_oe", m_oe, span(1, 6));
    check_output("rst_cmd_ready_after", 32'(u_if.cmd_ready), 32'h1);

    // normal command after reset release
    pad_q.push_back(16'h5A5A); exp_rd_q.push_back(16'h5A5A);
    apply_stimulus(1'b0, 2'd2, 5'd1, 0, 0, 8, 0, 0);
    check_output("post_rst_cs", m_cs, span(1, 4));
    check_output("post_rst_rn", m_rn, span(2, 3));
    check_output("post_rst_done", m_done, span(4, 4));
    check_output("post_rst_rd_valid", m_rdv, span(4, 4));

    // every scoreboard entry must have been consumed
    check_output("rd_queue_drained", 32'(exp_rd_q.size()), 32'h0);
    check_output("wr_queue_drained", 32'(exp_wr_q.size()), 32'h0);
    check_output("pad_queue_drained", 32'(pad_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
